// File: rtl/integrator_dump.sv
// Integrate-and-dump: sums 2^ACC_LEN_BITS valid samples per frame and strobes out the total.
// Optional clamping arithmetic is enabled by defining INTEGRATOR_DUMP_SATURATE_EN.
module integrator_dump #(
  parameter int DIN_WIDTH     = 5,
  parameter     DIN_IS_SIGNED = "TRUE",
  parameter int ACC_LEN_BITS  = 4,
  parameter int DOUT_WIDTH    = DIN_WIDTH + ACC_LEN_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_vld,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  sync_out
);

  localparam bit IS_SIGNED = (DIN_IS_SIGNED == "TRUE");
  localparam logic [ACC_LEN_BITS-1:0] CNT_LAST = '1;

  logic [DOUT_WIDTH-1:0]   ext;
  logic [DOUT_WIDTH-1:0]   acc;
  logic [DOUT_WIDTH-1:0]   sum;
  logic [ACC_LEN_BITS-1:0] cnt;

  generate
    if (IS_SIGNED) begin : g_sext
      assign ext = DOUT_WIDTH'($signed(din));
    end else begin : g_zext
      assign ext = DOUT_WIDTH'(din);
    end
  endgenerate

`ifdef INTEGRATOR_DUMP_SATURATE_EN
  localparam logic [DOUT_WIDTH-1:0] SMAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] SMIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
  logic [DOUT_WIDTH:0] sum_x;

  // One guard bit: signed overflow when the two top bits disagree, unsigned on carry-out.
  always_comb begin
    if (IS_SIGNED) sum_x = {acc[DOUT_WIDTH-1], acc} + {ext[DOUT_WIDTH-1], ext};
    else           sum_x = {1'b0, acc} + {1'b0, ext};
    sum = sum_x[DOUT_WIDTH-1:0];
    if (IS_SIGNED) begin
      if (sum_x[DOUT_WIDTH] != sum_x[DOUT_WIDTH-1])
        sum = sum_x[DOUT_WIDTH] ? SMIN : SMAX;
    end else if (sum_x[DOUT_WIDTH]) begin
      sum = '1;
    end
  end
`else
  assign sum = acc + ext;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      sync_out <= sync;
      dout_vld <= 1'b0;
      if (din_vld) begin
        // sync forces this sample to open a new frame, even if it would have closed one
        if (sync || cnt == '0) begin
          acc <= ext;
          cnt <= ACC_LEN_BITS'(1);
        end else if (cnt == CNT_LAST) begin
          acc      <= sum;
          dout     <= sum;
          dout_vld <= 1'b1;
          cnt      <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + ACC_LEN_BITS'(1);
        end
      end else if (sync) begin
        cnt <= '0;
      end
    end
  end

endmodule
